// File: rtl/simmem_linkedlist_bank_rr.sv
// Per-ID linked-list delay bank with one-entry output buffers and round-robin release.
// Optional in-module SVA checks are enabled by defining SIMMEM_LL_BANK_ASSERT_EN.
module simmem_linkedlist_bank_rr #(
    parameter int StructWidth   = 64,
    parameter int IDWidth       = 4,
    parameter int NumIds        = 16,
    parameter int TotalCapacity = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumIds-1:0]                    release_en_i,
    input  logic [StructWidth-1:0]               data_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    output logic [StructWidth-1:0]               data_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [$clog2(TotalCapacity+1)-1:0]   occupancy_o
);

    localparam int PayloadWidth = StructWidth - IDWidth;
    localparam int PtrWidth     = $clog2(TotalCapacity);
    localparam int OccWidth     = $clog2(TotalCapacity + 1);
    localparam int IdxWidth     = (NumIds > 1) ? $clog2(NumIds) : 1;

    logic [PayloadWidth-1:0] pool_data_q   [TotalCapacity];
    logic [PayloadWidth-1:0] pool_data_d   [TotalCapacity];
    logic [PtrWidth-1:0]     next_q        [TotalCapacity];
    logic [PtrWidth-1:0]     next_d        [TotalCapacity];
    logic [TotalCapacity-1:0] pool_valid_q, pool_valid_d;
    logic [PtrWidth-1:0]     head_q        [NumIds];
    logic [PtrWidth-1:0]     head_d        [NumIds];
    logic [PtrWidth-1:0]     tail_q        [NumIds];
    logic [PtrWidth-1:0]     tail_d        [NumIds];
    logic [NumIds-1:0]       list_valid_q, list_valid_d;
    logic [PayloadWidth-1:0] outbuf_q      [NumIds];
    logic [PayloadWidth-1:0] outbuf_d      [NumIds];
    logic [NumIds-1:0]       outbuf_valid_q, outbuf_valid_d;
    logic [IdxWidth-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OccWidth-1:0]     occupancy_q, occupancy_d;

    logic [IDWidth-1:0]      in_id_s;
    logic [IdxWidth-1:0]     in_idx_s;
    logic [PayloadWidth-1:0] in_payload_s;
    logic                    accept_s;
    logic [NumIds-1:0]       candidates_s;
    logic [IdxWidth-1:0]     grant_s;
    logic [IdxWidth-1:0]     scan_idx_s;
    logic                    release_s;
    logic [PtrWidth-1:0]     free_idx_s;
    logic                    direct_s;
    logic                    pool_push_s;
    logic                    pool_pop_s;

    assign in_id_s      = data_i[StructWidth-1 -: IDWidth];
    assign in_idx_s     = IdxWidth'(in_id_s);
    assign in_payload_s = data_i[PayloadWidth-1:0];

    // Ready depends on registered occupancy only, never on the output side.
    assign in_ready_o   = (occupancy_q != OccWidth'(TotalCapacity));
    assign accept_s     = in_valid_i && in_ready_o && !rst_i;
    assign candidates_s = outbuf_valid_q & release_en_i;
    assign out_valid_o  = !rst_i && (|candidates_s);
    assign release_s    = out_valid_o && out_ready_i;
    assign data_o       = out_valid_o ? {IDWidth'(grant_s), outbuf_q[grant_s]} : {StructWidth{1'b0}};
    assign occupancy_o  = occupancy_q;

    assign direct_s    = !list_valid_q[in_idx_s] &&
                         (!outbuf_valid_q[in_idx_s] || (release_s && (grant_s == in_idx_s)));
    assign pool_push_s = accept_s && !direct_s;
    assign pool_pop_s  = release_s && list_valid_q[grant_s];

    // Round-robin pick: scan offsets from high to low so the nearest candidate at/after rr_ptr wins.
    always_comb begin
        grant_s    = '0;
        scan_idx_s = '0;
        for (int i = NumIds - 1; i >= 0; i--) begin
            scan_idx_s = IdxWidth'((int'(rr_ptr_q) + i) % NumIds);
            grant_s    = candidates_s[scan_idx_s] ? scan_idx_s : grant_s;
        end
    end

    // Lowest-index free pool entry, from registered valid bits so a just-freed slot is not reused.
    always_comb begin
        free_idx_s = '0;
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            free_idx_s = pool_valid_q[i] ? free_idx_s : PtrWidth'(i);
        end
    end

    // Next-state: release/refill first, then place the accepted struct against the post-pop list state.
    always_comb begin
        pool_data_d    = pool_data_q;
        next_d         = next_q;
        pool_valid_d   = pool_valid_q;
        head_d         = head_q;
        tail_d         = tail_q;
        list_valid_d   = list_valid_q;
        outbuf_d       = outbuf_q;
        outbuf_valid_d = outbuf_valid_q;
        rr_ptr_d       = rr_ptr_q;
        occupancy_d    = occupancy_q;

        if (release_s) begin
            rr_ptr_d = (int'(grant_s) == NumIds - 1) ? '0 : grant_s + IdxWidth'(1);
            if (pool_pop_s) begin
                outbuf_d[grant_s]             = pool_data_q[head_q[grant_s]];
                pool_valid_d[head_q[grant_s]] = 1'b0;
                occupancy_d                   = occupancy_d - OccWidth'(1);
                if (head_q[grant_s] == tail_q[grant_s]) begin
                    list_valid_d[grant_s] = 1'b0;
                end else begin
                    head_d[grant_s] = next_q[head_q[grant_s]];
                end
            end else begin
                outbuf_valid_d[grant_s] = 1'b0;
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        if (accept_s && direct_s) begin
            outbuf_d[in_idx_s]       = in_payload_s;
            outbuf_valid_d[in_idx_s] = 1'b1;
        end else if (pool_push_s) begin
            pool_data_d[free_idx_s]  = in_payload_s;
            pool_valid_d[free_idx_s] = 1'b1;
            occupancy_d              = occupancy_d + OccWidth'(1);
            if (list_valid_d[in_idx_s]) begin
                next_d[tail_q[in_idx_s]] = free_idx_s;
                tail_d[in_idx_s]         = free_idx_s;
            end else begin
                head_d[in_idx_s]       = free_idx_s;
                tail_d[in_idx_s]       = free_idx_s;
                list_valid_d[in_idx_s] = 1'b1;
            end
        end else begin
            occupancy_d = occupancy_d;
        end
    end

    // State registers with synchronous reset discarding all content.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pool_valid_q   <= '0;
            list_valid_q   <= '0;
            outbuf_valid_q <= '0;
            rr_ptr_q       <= '0;
            occupancy_q    <= '0;
            for (int i = 0; i < TotalCapacity; i++) begin
                pool_data_q[i] <= '0;
                next_q[i]      <= '0;
            end
            for (int i = 0; i < NumIds; i++) begin
                head_q[i]   <= '0;
                tail_q[i]   <= '0;
                outbuf_q[i] <= '0;
            end
        end else begin
            pool_data_q    <= pool_data_d;
            next_q         <= next_d;
            pool_valid_q   <= pool_valid_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            list_valid_q   <= list_valid_d;
            outbuf_q       <= outbuf_d;
            outbuf_valid_q <= outbuf_valid_d;
            rr_ptr_q       <= rr_ptr_d;
            occupancy_q    <= occupancy_d;
        end
    end

`ifdef SIMMEM_LL_BANK_ASSERT_EN
    a_no_accept_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(accept_s && (occupancy_q == OccWidth'(TotalCapacity))));
    a_legal_id: assert property (@(posedge clk_i) disable iff (rst_i)
        in_valid_i |-> (int'(in_id_s) < NumIds));
    a_occ_popcount: assert property (@(posedge clk_i) disable iff (rst_i)
        occupancy_q == OccWidth'($countones(pool_valid_q)));
    a_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i) |=>
        (!($stable(release_en_i) && $stable(outbuf_valid_q)) || $stable(data_o)));
    a_no_reuse: assert property (@(posedge clk_i) disable iff (rst_i)
        (pool_push_s && pool_pop_s) |-> (free_idx_s != head_q[grant_s]));
`endif

endmodule

// File: tb/tb_simmem_linkedlist_bank_rr.sv
// Directed bench: stimulus pushes expected outputs into a queue, a negedge monitor pops and compares.
module tb_simmem_linkedlist_bank_rr;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] release_en_i;
    logic [63:0] data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [5:0]  occupancy_o;

    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    int checks = 0;
    int errors = 0;

    simmem_linkedlist_bank_rr #(
        .StructWidth(64), .IDWidth(4), .NumIds(16), .TotalCapacity(32)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .release_en_i(release_en_i),
        .data_i(data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_o(data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .occupancy_o(occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] mk(input logic [3:0] id, input logic [59:0] p);
        return {id, p};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic [59:0] p, input bit expect_out);
        data_i     = mk(id, p);
        in_valid_i = 1'b1;
        if (expect_out) exp_q.push_back(mk(id, p));
        @(negedge clk_i);
        chk("push_in_ready", 64'(in_ready_o), 64'd1);
        step();
        in_valid_i = 1'b0;
        data_i     = 64'd0;
    endtask

    // Scoreboard monitor: every output handshake must match the queue head.
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none", data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_data", data_o, mon_exp);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; data_i = 64'd0;
        release_en_i = 16'd0; out_ready_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_in_ready", 64'(in_ready_o), 64'd1);
        chk("reset_out_valid", 64'(out_valid_o), 64'd0);
        chk("reset_occ", 64'(occupancy_o), 64'd0);
        chk("reset_data", data_o, 64'd0);
        step();

        // ID3 FIFO order with pool refill
        push(4'd3, 60'hA, 1'b1);
        push(4'd3, 60'hB, 1'b1);
        push(4'd3, 60'hC, 1'b1);
        release_en_i = 16'h0008;
        @(negedge clk_i); chk("id3_occ0", 64'(occupancy_o), 64'd2); step();
        @(negedge clk_i); chk("id3_occ1", 64'(occupancy_o), 64'd1); step();
        @(negedge clk_i); chk("id3_occ2", 64'(occupancy_o), 64'd0); step();
        @(negedge clk_i); chk("id3_drained", 64'(out_valid_o), 64'd0); step();
        release_en_i = 16'd0;

        // Reset mid-traffic with 5 pool entries
        for (int i = 0; i < 6; i++) push(4'd4, 60'(64 + i), 1'b0);
        @(negedge clk_i); chk("mid_occ", 64'(occupancy_o), 64'd5); step();
        rst_i = 1'b1; release_en_i = 16'hFFFF;
        @(negedge clk_i); chk("rst_cycle_out_valid", 64'(out_valid_o), 64'd0); step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_occ", 64'(occupancy_o), 64'd0);
        chk("post_rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready_o), 64'd1);
        step();
        release_en_i = 16'd0;

        // Fill pool and all output buffers
        for (int i = 0; i < 48; i++) push(4'(i % 16), 60'(256 + i), (i == 0));
        @(negedge clk_i);
        chk("full_in_ready", 64'(in_ready_o), 64'd0);
        chk("full_occ", 64'(occupancy_o), 64'd32);
        step();
        in_valid_i = 1'b1; data_i = mk(4'd0, 60'hFFF);
        @(negedge clk_i); chk("full_ready_held", 64'(in_ready_o), 64'd0); step();
        in_valid_i = 1'b0; data_i = 64'd0;
        @(negedge clk_i); chk("full_occ_hold", 64'(occupancy_o), 64'd32); step();
        release_en_i = 16'h0001;
        step();
        release_en_i = 16'd0;
        @(negedge clk_i);
        chk("after_rel_in_ready", 64'(in_ready_o), 64'd1);
        chk("after_rel_occ", 64'(occupancy_o), 64'd31);
        step();
        rst_i = 1'b1; step(); step(); rst_i = 1'b0;

        // Round robin: 1,2,5 then rr_ptr=2 gives 5 before 1
        push(4'd1, 60'h1A, 1'b1);
        push(4'd2, 60'h2A, 1'b1);
        push(4'd5, 60'h5A, 1'b1);
        release_en_i = 16'h0026;
        step(); step(); step();
        @(negedge clk_i); chk("rr_round1_drained", 64'(out_valid_o), 64'd0); step();
        release_en_i = 16'd0;
        push(4'd1, 60'h1B, 1'b1);
        push(4'd5, 60'h5B, 1'b1);
        release_en_i = 16'h0002;
        step();
        release_en_i = 16'd0;
        push(4'd1, 60'h1C, 1'b1);
        release_en_i = 16'h0022;
        step(); step();
        @(negedge clk_i);
        chk("rr_round2_drained", 64'(out_valid_o), 64'd0);
        chk("rr_queue_empty", 64'(exp_q.size()), 64'd0);
        step();
        release_en_i = 16'd0;

        // Same-cycle push and release on ID7 with empty list
        push(4'd7, 60'h7A, 1'b1);
        in_valid_i = 1'b1; data_i = mk(4'd7, 60'h7B);
        exp_q.push_back(mk(4'd7, 60'h7B));
        release_en_i = 16'h0080;
        @(negedge clk_i);
        chk("same_occ", 64'(occupancy_o), 64'd0);
        chk("same_in_ready", 64'(in_ready_o), 64'd1);
        step();
        in_valid_i = 1'b0; data_i = 64'd0; release_en_i = 16'd0;
        @(negedge clk_i);
        chk("same_occ_after", 64'(occupancy_o), 64'd0);
        chk("same_masked", 64'(out_valid_o), 64'd0);
        step();
        release_en_i = 16'h0080;
        @(negedge clk_i); chk("same_refilled", 64'(out_valid_o), 64'd1); step();
        @(negedge clk_i); chk("same_drained", 64'(out_valid_o), 64'd0); step();
        release_en_i = 16'd0;
        rst_i = 1'b1; step(); rst_i = 1'b0;

        // Backpressure on ID2 with rr_ptr held at 0
        push(4'd2, 60'h2F, 1'b1);
        push(4'd3, 60'h3E, 1'b1);
        push(4'd2, 60'h20, 1'b1);
        release_en_i = 16'h0004; out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("bp_data", data_o, mk(4'd2, 60'h2F));
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_occ", 64'(occupancy_o), 64'd1);
            step();
        end
        release_en_i = 16'h000C; out_ready_i = 1'b1;
        step(); step(); step();
        @(negedge clk_i);
        chk("bp_drained", 64'(out_valid_o), 64'd0);
        chk("bp_occ_end", 64'(occupancy_o), 64'd0);
        step();
        release_en_i = 16'd0;

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simmem_linkedlist_bank_rr.md
Name: simmem_linkedlist_bank_rr

Overview:
- Parametrised successor of the per-ID linked-list delay bank in the simulated-memory response path.
- Stores incoming structs (ID in the MSBs) in a shared flop-based pool. Entries are chained into one FIFO linked list per ID.
- Each ID has a one-entry output buffer.
- A round-robin arbiter releases a buffered head whenever the releaser enables that ID.

Parameters:
- StructWidth, 64, full message width including ID field.
- IDWidth, 4, width of ID field (MSBs of data_i).
- NumIds, 16, number of IDs tracked; must be ≤ 2**IDWidth; IDs ≥ NumIds are illegal.
- TotalCapacity, 32, shared pool entries (excludes output buffers); ≥ 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- release_en_i  in  NumIds  per-ID release permission from releaser.
- data_i  in  StructWidth  input struct, ID in [StructWidth-1 -: IDWidth].
- in_valid_i  in  1  input valid.
- in_ready_o  out  1  input ready.
- data_o  out  StructWidth  output struct with ID re-attached.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  output ready.
- occupancy_o  out  $clog2(TotalCapacity+1)  pool entries in use.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - all pool valid bits, output buffer valid bits, heads/tails and RR pointer cleared to 0.
  - occupancy_o = 0, out_valid_o = 0, in_ready_o = 1, data_o = 0.
  - Reset mid-operation discards all content; no output is produced in the reset cycle.
- Input handshake:
  - Transfer when in_valid_i && in_ready_o.
  - in_ready_o = (occupancy_q != TotalCapacity). It is registered-state only, with no combinational path from out_ready_i.
- Storage rule for an accepted struct of ID k (payload = data_i without ID):
  - Case a: outbuf[k] empty, or being released this cycle, and list k empty → payload goes straight into outbuf[k]; the pool is untouched.
  - Case b: otherwise → written to the lowest-index free pool entry (priority encoder). The entry is linked after tail[k], or becomes head=tail if list k is empty. Occupancy increments.
- Release arbitration:
  - Candidate set = {k : outbuf_valid[k] && release_en_i[k]}.
  - out_valid_o = |candidates.
  - Grant = first candidate at or after rr_ptr, wrapping modulo NumIds.
  - data_o = {grant ID, outbuf[grant]}, combinational from state and release_en_i.
  - rr_ptr advances to grant+1 (mod NumIds) only on an output handshake. It holds otherwise.
- Refill on release of ID g:
  - If list g is non-empty, outbuf[g] takes pool[head[g]] in the same cycle (visible next cycle). head[g] ← next[head[g]], the entry is freed, and occupancy decrements.
  - Else case a above may refill outbuf[g].
  - Else outbuf_valid[g] clears.
- Simultaneous input and release:
  - Both happen in one cycle. occupancy_o changes by (+1 write) + (−1 free), net 0 when both hit the pool.
  - A freed entry may not be reused in the same cycle; the free vector uses registered valid bits.
- Latency: input to output is 1 cycle minimum (case a accepted at N, out_valid_o at N+1 if enabled).
- Per-ID ordering: strict FIFO within an ID; no ordering guarantee across IDs.
- Full boundary: at occupancy = TotalCapacity, in_ready_o = 0 even if the input would take case a. This is deliberately conservative.
- Empty boundary: with no buffered IDs enabled, out_valid_o = 0 and data_o is don't-care.
- Illegal ID (≥ NumIds): flagged by assertion; behaviour is unspecified.

Optional Feature:
- Macro SIMMEM_LL_BANK_ASSERT_EN.
- Defined: bind-free SVA inside the module checks:
  - no accept when full;
  - no illegal ID;
  - occupancy equals popcount of pool valid bits;
  - data_o stable while out_valid_o && !out_ready_i && release_en_i unchanged;
  - no pool entry both freed and allocated in the same cycle.
- Undefined: no assertions are compiled; functional behaviour is identical.

Test Plan:
- Reset, then idle → in_ready_o=1, out_valid_o=0, occupancy_o=0; assert rst_i mid-traffic with 5 entries stored → next cycle occupancy_o=0, out_valid_o=0.
- Push ID3 payloads A, B, C with release_en_i=0, then set bit 3 with out_ready_i=1 → A, B, C emitted in order on consecutive cycles with data_o[63:60]=3; occupancy 2→1→0.
- Fill pool: TotalCapacity+NumIds pushes with releases off → in_ready_o drops after TotalCapacity+NumIds accepts (NumIds to outbufs, rest to pool), occupancy_o=32; one release → in_ready_o=1 next cycle.
- IDs 1, 2, 5 buffered, all enabled, out_ready_i=1 → grant order 1, 2, 5 and rr_ptr=6; refill ID1 and ID5, then ID1 wins only after ID5 when rr_ptr=2.
- Same-cycle push ID7 while ID7 outbuf is released with empty list → new payload in outbuf[7] next cycle, occupancy unchanged.
- Backpressure: out_ready_i=0 for 4 cycles with ID2 valid → data_o stable, rr_ptr unchanged, no entry lost.
